logic_reduce_unit: RTL and testbench
====================================

Name: logic_reduce_unit

Overview:
- Parametrised, registered successor to the two-input OR primitive.
- Reduces NUM_IN lanes of WIDTH bits bitwise with a selectable logic operation.
- Optionally accumulates the result across a multi-beat packet.
- Valid/ready on both sides; sits in the ALU/datapath as a streaming logic-reduction stage for flag and mask generation.

Parameters:
- WIDTH, 8: bits per lane and result width.
- NUM_IN, 4: number of input lanes, >=2.
- CNT_W, 4: width of the beat counter (out_beats).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat.
- in_data  in  NUM_IN*WIDTH  lanes; lane k = in_data[k*WIDTH +: WIDTH].
- in_op  in  3  operation: 000 OR, 001 AND, 010 XOR, 011 NOR, 100 NAND, 101 XNOR, 110/111 illegal.
- in_last  in  1  final beat of packet.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  WIDTH  packet result.
- out_beats  out  CNT_W  beats in packet, saturating.
- out_any  out  1  OR-reduction of out_data.
- out_err  out  1  packet used an illegal op.

Behaviour:
- Handshakes
  - Beat accepted when in_valid && in_ready.
  - Result consumed when out_valid && out_ready.
- Reset, when rst_n=0 at a clock edge:
  - state=IDLE; out_valid=0, out_data=0, out_beats=0, out_any=0, out_err=0; accumulator=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - A packet in flight is discarded; nothing is emitted for it.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE: in_ready=1.
  - On accept, latch in_op as the packet op, load the accumulator with the beat result, and set beats=1.
  - Go to HOLD if in_last, else ACCUM.
- ACCUM: in_ready=1.
  - On accept, combine acc = acc <base> beat_result and set beats=min(beats+1, 2^CNT_W-1).
  - Go to HOLD if in_last.
  - in_op is ignored on non-first beats.
- HOLD: in_ready=0, out_valid=1.
  - On out_ready, go to IDLE; out_valid falls the next cycle.
  - out_data, out_beats, out_any and out_err hold stable while out_valid && !out_ready.
- Beat result: bitwise reduction across all NUM_IN lanes with the base op.
  - Base op is OR for OR/NOR, AND for AND/NAND, XOR for XOR/XNOR.
  - Inversion (NOR/NAND/XNOR) is applied once, to the final accumulator, when entering HOLD. It is never applied per beat.
- Illegal op (110/111): out_data=0, out_any=0, out_err=1, out_beats counted normally.
- Latency: out_valid asserts the cycle after the in_last beat is accepted.
- Throughput: one packet per (beats+1) cycles at minimum; no overlap of HOLD with the next packet's first beat.
- Boundaries
  - in_valid while in HOLD: not accepted; the source must hold its beat.
  - in_last on the first beat: single-beat packet, IDLE to HOLD directly.
  - Beat counter saturates at 2^CNT_W-1 with no wrap.
  - in_valid=0 while in ACCUM: stay in ACCUM indefinitely; the accumulator holds.
  - X-free outputs required after reset.

Test Plan:
1. OR single beat
   - Stimulus: WIDTH=8, NUM_IN=4, op=000, lanes {0x01,0x02,0x04,0x80}, last=1.
   - Required: next cycle out_valid=1, out_data=0x87, out_beats=1, out_any=1, out_err=0.
2. NAND two-beat packet
   - Stimulus: op=100; beat 1 {0xFF,0xF0,0xFF,0xFF}; beat 2 {0x3F,0xFF,0xFF,0xFF}, last=1. Present op=000 on beat 2.
   - Required: out_data=0xCF, out_beats=2, out_err=0. The beat-2 op is ignored.
3. XOR and XNOR
   - Stimulus: lanes {0xAA,0x55,0x0F,0x00}.
   - Required: op=010 gives out_data=0xF0. op=101 gives 0x0F.
   - Stimulus: NOR with all lanes 0x00.
   - Required: out_data=0xFF.
4. Backpressure
   - Stimulus: hold out_ready=0 for 5 cycles after out_valid while in_valid=1 with a new beat.
   - Required: in_ready=0 and out_data constant throughout. Assert out_ready=1: out_valid=0 next cycle, then the new beat is accepted in IDLE.
5. Illegal op and saturation
   - Stimulus: op=110, single beat.
   - Required: out_err=1, out_data=0x00, out_any=0.
   - Stimulus: OR packet of 20 beats with CNT_W=4.
   - Required: out_beats=15.
6. Reset mid-packet
   - Stimulus: accept beat {0xFF×4} with op=001 and last=0; pulse rst_n=0 for one cycle; then send op=001, {0x0F,0xFF,0xFF,0xFF}, last=1.
   - Required: out_valid=0 during reset, out_data=0x0F, out_beats=1. The earlier beat has no effect.

Source files
------------

// File: rtl/logic_reduce_unit.sv
// Streaming bitwise reduction unit: folds NUM_IN lanes per beat with a selectable
// logic op, accumulates across a packet, and presents one registered result per packet.
module logic_reduce_unit #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [2:0]              in_op,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CNT_W-1:0]        out_beats,
  output logic                    out_any,
  output logic                    out_err
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    BASE_OR,
    BASE_AND,
    BASE_XOR
  } base_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [2:0]        op_q, op_d;
  logic [CNT_W-1:0]  beats_q, beats_d;
  logic              err_q, err_d;

  logic              accept;
  logic [2:0]        cur_op;
  base_t             cur_base;
  logic              cur_illegal;
  logic              cur_invert;
  logic [WIDTH-1:0]  lane_or, lane_and, lane_xor;
  logic [WIDTH-1:0]  beat_res;
  logic [WIDTH-1:0]  merged;
  logic [WIDTH-1:0]  final_res;

  function automatic base_t base_of(input logic [2:0] op);
    case (op)
      3'b001, 3'b100: base_of = BASE_AND;
      3'b010, 3'b101: base_of = BASE_XOR;
      default:        base_of = BASE_OR;
    endcase
  endfunction

  assign accept    = in_valid && in_ready;
  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign out_beats = beats_q;
  assign out_any   = |data_q;
  assign out_err   = err_q;

  // The packet op is only taken from in_op on the first beat; later beats use the latched op.
  assign cur_op      = (state_q == IDLE) ? in_op : op_q;
  assign cur_base    = base_of(cur_op);
  assign cur_illegal = (cur_op[2:1] == 2'b11);
  assign cur_invert  = (cur_op == 3'b011) || (cur_op == 3'b100) || (cur_op == 3'b101);

  always_comb begin
    lane_or  = '0;
    lane_and = '1;
    lane_xor = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      lane_or  = lane_or  | in_data[k*WIDTH +: WIDTH];
      lane_and = lane_and & in_data[k*WIDTH +: WIDTH];
      lane_xor = lane_xor ^ in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    case (cur_base)
      BASE_AND: beat_res = lane_and;
      BASE_XOR: beat_res = lane_xor;
      default:  beat_res = lane_or;
    endcase
  end

  always_comb begin
    if (state_q == IDLE) begin
      merged = beat_res;
    end else begin
      case (cur_base)
        BASE_AND: merged = acc_q & beat_res;
        BASE_XOR: merged = acc_q ^ beat_res;
        default:  merged = acc_q | beat_res;
      endcase
    end
  end

  // Inversion is applied once to the folded packet value, never per beat.
  always_comb begin
    if (cur_illegal) begin
      final_res = '0;
    end else if (cur_invert) begin
      final_res = ~merged;
    end else begin
      final_res = merged;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    data_d  = data_q;
    op_d    = op_q;
    beats_d = beats_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = in_op;
          acc_d   = merged;
          beats_d = CNT_W'(1);
          if (in_last) begin
            state_d = HOLD;
            data_d  = final_res;
            err_d   = cur_illegal;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d   = merged;
          beats_d = (beats_q == '1) ? beats_q : beats_q + CNT_W'(1);
          if (in_last) begin
            state_d = HOLD;
            data_d  = final_res;
            err_d   = cur_illegal;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      data_q  <= '0;
      op_q    <= '0;
      beats_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      op_q    <= op_d;
      beats_q <= beats_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_logic_reduce_unit.sv
// Self-checking bench for logic_reduce_unit: directed vector table, hand-written
// multi-cycle sequences, and random packets checked against a per-bit counting model.
module tb_logic_reduce_unit;
  localparam int W = 8;
  localparam int N = 4;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic [2:0]     in_op;
  logic           in_last;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [C-1:0]   out_beats;
  logic           out_any;
  logic           out_err;

  int tests = 0;
  int fails = 0;
  logic [N*W-1:0] pkt[$];

  always #5 clk = ~clk;

  logic_reduce_unit #(.WIDTH(W), .NUM_IN(N), .CNT_W(C)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_op(in_op), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_beats(out_beats), .out_any(out_any), .out_err(out_err)
  );

  typedef struct {
    logic [2:0]     op;
    logic [N*W-1:0] data;
    logic [W-1:0]   exp_data;
    logic           exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per output bit, count ones over every lane of every beat, then apply the op rule.
  function automatic logic [W-1:0] model_result(input logic [2:0] op);
    logic [W-1:0] r;
    int total;
    total = N * pkt.size();
    for (int b = 0; b < W; b++) begin
      int cnt;
      cnt = 0;
      foreach (pkt[i])
        for (int l = 0; l < N; l++)
          cnt += int'(pkt[i][l*W+b]);
      case (op)
        3'd0: r[b] = (cnt > 0);
        3'd3: r[b] = !(cnt > 0);
        3'd1: r[b] = (cnt == total);
        3'd4: r[b] = !(cnt == total);
        3'd2: r[b] = (cnt % 2 == 1);
        3'd5: r[b] = !(cnt % 2 == 1);
        default: r[b] = 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic send_beat(input logic [N*W-1:0] d, input logic [2:0] op, input logic last);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_pkt(input logic [2:0] op, input int max_gap);
    for (int i = 0; i < pkt.size(); i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_beat(pkt[i], (i == 0) ? op : 3'($urandom_range(0, 7)), i == pkt.size() - 1);
    end
  endtask

  task automatic expect_result(input string name, input logic [W-1:0] ed,
                               input logic [C-1:0] eb, input logic ee, input int stall);
    check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({name, "_data"},  {24'b0, out_data},  {24'b0, ed});
    check({name, "_beats"}, {28'b0, out_beats}, {28'b0, eb});
    check({name, "_any"},   {31'b0, out_any},   {31'b0, |ed});
    check({name, "_err"},   {31'b0, out_err},   {31'b0, ee});
    repeat (stall) begin
      @(negedge clk);
      check({name, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
      check({name, "_hold_data"},  {24'b0, out_data},  {24'b0, ed});
      check({name, "_hold_ready"}, {31'b0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_drop"}, {31'b0, out_valid}, 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    logic [2:0] rop;
    int         rlen;
    logic [W-1:0] exp_d;

    vecs[0] = '{3'b000, {8'h80, 8'h04, 8'h02, 8'h01}, 8'h87, 1'b0};
    vecs[1] = '{3'b010, {8'h00, 8'h0F, 8'h55, 8'hAA}, 8'hF0, 1'b0};
    vecs[2] = '{3'b101, {8'h00, 8'h0F, 8'h55, 8'hAA}, 8'h0F, 1'b0};
    vecs[3] = '{3'b011, 32'h0000_0000,                8'hFF, 1'b0};
    vecs[4] = '{3'b110, {8'hFF, 8'h12, 8'h34, 8'h56}, 8'h00, 1'b1};
    vecs[5] = '{3'b111, 32'hFFFF_FFFF,                8'h00, 1'b1};
    vecs[6] = '{3'b001, {8'hF3, 8'h7F, 8'hFB, 8'hFF}, 8'h73, 1'b0};
    vecs[7] = '{3'b100, 32'hFFFF_FFFF,                8'h00, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_op = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_data",  {24'b0, out_data},  32'd0);
    check("rst_beats", {28'b0, out_beats}, 32'd0);
    check("rst_any",   {31'b0, out_any},   32'd0);
    check("rst_err",   {31'b0, out_err},   32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    foreach (vecs[i]) begin
      pkt.delete();
      pkt.push_back(vecs[i].data);
      send_pkt(vecs[i].op, 0);
      expect_result($sformatf("vec%0d", i), vecs[i].exp_data, 4'd1, vecs[i].exp_err, i % 3);
    end

    // NAND over two beats; op shown on beat 2 must be ignored.
    send_beat({8'hFF, 8'hFF, 8'hF0, 8'hFF}, 3'b100, 1'b0);
    check("nand_mid_valid", {31'b0, out_valid}, 32'd0);
    send_beat({8'hFF, 8'hFF, 8'hFF, 8'h3F}, 3'b000, 1'b1);
    expect_result("nand2", 8'hCF, 4'd2, 1'b0, 0);

    // Backpressure with a new beat waiting at the input.
    send_beat({8'h00, 8'h00, 8'h0C, 8'h30}, 3'b000, 1'b1);
    in_valid = 1'b1; in_data = {8'h00, 8'h00, 8'h01, 8'h10}; in_op = 3'b000; in_last = 1'b1;
    expect_result("bp", 8'h3C, 4'd1, 1'b0, 5);
    check("bp_idle_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    expect_result("bp_next", 8'h11, 4'd1, 1'b0, 0);

    // Beat counter saturation.
    pkt.delete();
    repeat (20) pkt.push_back(32'h0000_0001);
    send_pkt(3'b000, 1);
    expect_result("sat", 8'h01, 4'd15, 1'b0, 0);

    // Reset in the middle of a packet discards it.
    send_beat(32'hFFFF_FFFF, 3'b001, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    rst_n = 1'b1;
    send_beat({8'hFF, 8'hFF, 8'hFF, 8'h0F}, 3'b001, 1'b1);
    expect_result("rst_mid", 8'h0F, 4'd1, 1'b0, 0);

    // Random packets against the counting model.
    for (int p = 0; p < 40; p++) begin
      rop  = 3'($urandom_range(0, 7));
      rlen = $urandom_range(1, 20);
      pkt.delete();
      for (int b = 0; b < rlen; b++)
        pkt.push_back(($urandom_range(0, 2) == 0) ? ~($urandom & $urandom & $urandom) : $urandom);
      exp_d = model_result(rop);
      send_pkt(rop, 2);
      expect_result($sformatf("rnd%0d", p), exp_d, (rlen > 15) ? 4'd15 : 4'(rlen),
                    rop[2:1] == 2'b11, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
